// File: rtl/cell_pos_streamer.sv
// rtl/cell_pos_streamer.sv - reads one cell's particle positions from RAM and streams them with backpressure
module cell_pos_streamer #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rden_o,
    output logic                  mem_wren_o,
    input  logic [DATA_WIDTH-1:0] mem_q_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_pos_o,
    output logic [ADDR_WIDTH-1:0] out_pid_o,
    output logic                  out_last_o,
    output logic [ADDR_WIDTH-1:0] particle_count_o,
    output logic                  count_err_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_CNT, S_WAIT1, S_WAIT2, S_ISSUE, S_DRAIN, S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, next_addr_q, count_q, push_pid_q;
    logic                  cnt_err_q;
    logic [1:0]            dly_q;

    logic [DATA_WIDTH-1:0] pos_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pid_mem [FIFO_DEPTH];
    logic                  last_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         occ_q;

    logic                  rden, issue, push, pop, credit_ok, cnt_over;
    logic [ADDR_WIDTH-1:0] issue_addr, raw_cnt, clamped_cnt;
    logic [1:0]            inflight;

    // Reads in flight plus buffered entries bound how many more words may arrive.
    assign inflight    = {1'b0, dly_q[1]} + {1'b0, dly_q[0]};
    assign credit_ok   = (32'(inflight) + 32'(occ_q)) <= 32'(FIFO_DEPTH - 1);
    assign raw_cnt     = mem_q_i[ADDR_WIDTH-1:0];
    assign cnt_over    = raw_cnt > MAX_CNT;
    assign clamped_cnt = cnt_over ? MAX_CNT : raw_cnt;
    assign push        = dly_q[1];
    assign out_valid_o = (occ_q != '0);
    assign pop         = out_valid_o && out_ready_i;

    // Next-state and read-issue decode.
    always_comb begin
        state_d    = state_q;
        rden       = 1'b0;
        issue      = 1'b0;
        issue_addr = addr_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_RD_CNT;
            S_RD_CNT: begin
                rden       = 1'b1;
                issue_addr = '0;
                state_d    = S_WAIT1;
            end
            S_WAIT1:  state_d = S_WAIT2;
            S_WAIT2:  state_d = (clamped_cnt == '0) ? S_FINISH : S_ISSUE;
            S_ISSUE: begin
                if (credit_ok) begin
                    rden       = 1'b1;
                    issue      = 1'b1;
                    issue_addr = next_addr_q;
                    if (next_addr_q == count_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN:  if (pop && last_mem[rd_ptr_q]) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control state, address tracking and count capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            next_addr_q <= '0;
            count_q     <= '0;
            push_pid_q  <= '0;
            cnt_err_q   <= 1'b0;
            dly_q       <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= {dly_q[0], issue};
            if (rden) addr_q <= issue_addr;
            if (state_q == S_IDLE && start_i) begin
                cnt_err_q  <= 1'b0;
                push_pid_q <= ADDR_WIDTH'(1);
            end
            if (state_q == S_WAIT2) begin
                count_q     <= clamped_cnt;
                cnt_err_q   <= cnt_over;
                next_addr_q <= ADDR_WIDTH'(1);
            end
            if (issue) next_addr_q <= next_addr_q + 1'b1;
            if (push) push_pid_q <= push_pid_q + 1'b1;
        end
    end

    // Skid FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      occ_q <= occ_q + 1'b1;
            else if (!push && pop) occ_q <= occ_q - 1'b1;
        end
    end

    // FIFO storage; contents are only visible while occupancy is non-zero.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pos_mem[wr_ptr_q]  <= mem_q_i;
            pid_mem[wr_ptr_q]  <= push_pid_q;
            last_mem[wr_ptr_q] <= (push_pid_q == count_q);
        end
    end

    assign mem_addr_o       = issue_addr;
    assign mem_rden_o       = rden;
    assign mem_wren_o       = 1'b0;
    assign out_pos_o        = out_valid_o ? pos_mem[rd_ptr_q] : '0;
    assign out_pid_o        = out_valid_o ? pid_mem[rd_ptr_q] : '0;
    assign out_last_o       = out_valid_o ? last_mem[rd_ptr_q] : 1'b0;
    assign particle_count_o = count_q;
    assign count_err_o      = cnt_err_q;
    assign busy_o           = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done_o           = (state_q == S_FINISH);

endmodule

// File: tb/tb_cell_pos_streamer.sv
// tb/tb_cell_pos_streamer.sv - self-checking bench for cell_pos_streamer
module tb_cell_pos_streamer;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rden, mem_wren;
    logic [DW-1:0] mem_q;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_pos;
    logic [AW-1:0] out_pid;
    logic          out_last;
    logic [AW-1:0] particle_count;
    logic          count_err, busy, done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cell_pos_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .mem_addr_o(mem_addr), .mem_rden_o(mem_rden), .mem_wren_o(mem_wren), .mem_q_i(mem_q),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pos_o(out_pos), .out_pid_o(out_pid),
        .out_last_o(out_last), .particle_count_o(particle_count), .count_err_o(count_err),
        .busy_o(busy), .done_o(done)
    );

    // RAM model with a fixed 2-cycle read latency
    logic [DW-1:0] ram [0:255];
    logic [AW-1:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        a1 <= mem_addr;
        a2 <= a1;
    end
    assign mem_q = ram[a2];

    function automatic logic [DW-1:0] pos_of(input int i);
        return {32'(i * 3 + 256), 32'(i * 5 + 7), 32'(32'hC0DE0000 + i)};
    endfunction

    typedef struct {
        logic [DW-1:0] pos;
        logic [AW-1:0] pid;
        logic          last;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model of a cell: raw count at address 0, particles 1..min(raw, PN-1)
    task automatic load_cell(input int raw);
        int n;
        ram[0] = DW'(raw);
        n = (raw > PN - 1) ? PN - 1 : raw;
        for (int i = 1; i <= n; i++) exp_q.push_back('{pos_of(i), AW'(i), (i == n)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        for (int k = 0; k < max && !done; k++) step();
        chk("done_reached", done, 1'b1);
    endtask

    // Ready pattern 1,0,0 repeating when enabled
    logic pat_en = 1'b0;
    int   ph = 0;
    always @(posedge clk) begin
        #1;
        if (pat_en) begin
            out_ready = (ph == 0);
            ph = (ph + 1) % 3;
        end
    end

    // Stream checker: transfers against the model, stall stability, credit and address bounds
    int            outstanding = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] p_pos;
    logic [AW-1:0] p_pid;
    logic          p_last;
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            chk("mem_wren", mem_wren, 1'b0);
            if (mem_rden) chk("addr_in_range", mem_addr < AW'(PN), 1'b1);
            if (mem_rden && mem_addr != '0) begin
                chk("credit", outstanding <= FD - 1, 1'b1);
                outstanding++;
            end
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_pos", out_pos, p_pos);
                chk("stall_pid", out_pid, p_pid);
                chk("stall_last", out_last, p_last);
            end
            if (out_valid && out_ready) begin
                outstanding--;
                if (exp_q.size() == 0) begin
                    chk("unexpected_transfer_pid", out_pid, 0);
                    chk("unexpected_transfer", 1'b1, 1'b0);
                end else begin
                    chk("xfer_pos", out_pos, exp_q[0].pos);
                    chk("xfer_pid", out_pid, exp_q[0].pid);
                    chk("xfer_last", out_last, exp_q[0].last);
                    void'(exp_q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            p_pos  = out_pos;
            p_pid  = out_pid;
            p_last = out_last;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_pos"}, out_pos, '0);
        chk({tag, "_pid"}, out_pid, '0);
        chk({tag, "_last"}, out_last, 1'b0);
        chk({tag, "_rden"}, mem_rden, 1'b0);
        chk({tag, "_addr"}, mem_addr, '0);
        chk({tag, "_pcount"}, particle_count, '0);
        chk({tag, "_cerr"}, count_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        int found, ndone;
        for (int i = 0; i < 256; i++) ram[i] = pos_of(i);

        rst = 1'b1;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // count 3, ready held high: exact cycle positions
        load_cell(3);
        pulse_start();
        chk("t1_c1_busy", busy, 1'b1);
        chk("t1_c1_rden", mem_rden, 1'b1);
        chk("t1_c1_addr", mem_addr, 0);
        repeat (3) step();
        chk("t1_c4_rden", mem_rden, 1'b1);
        chk("t1_c4_addr", mem_addr, 1);
        repeat (2) step();
        chk("t1_c6_valid", out_valid, 1'b0);
        step();
        chk("t1_c7_valid", out_valid, 1'b1);
        chk("t1_c7_pid", out_pid, 1);
        chk("t1_c7_last", out_last, 1'b0);
        step();
        chk("t1_c8_pid", out_pid, 2);
        chk("t1_c8_last", out_last, 1'b0);
        step();
        chk("t1_c9_pid", out_pid, 3);
        chk("t1_c9_last", out_last, 1'b1);
        step();
        chk("t1_c10_done", done, 1'b1);
        chk("t1_c10_busy", busy, 1'b0);
        chk("t1_pcount", particle_count, 3);
        step();
        chk("t1_c11_done", done, 1'b0);
        chk("t1_left", exp_q.size(), 0);

        // count 0: no stream, done in cycle 4
        load_cell(0);
        pulse_start();
        for (int c = 1; c <= 3; c++) begin
            chk("t2_busy", busy, 1'b1);
            chk("t2_done_early", done, 1'b0);
            chk("t2_valid", out_valid, 1'b0);
            step();
        end
        chk("t2_done", done, 1'b1);
        chk("t2_busy_fin", busy, 1'b0);
        chk("t2_pcount", particle_count, 0);
        step();

        // count 10 with ready toggling 1,0,0
        load_cell(10);
        ph = 0;
        pat_en = 1'b1;
        pulse_start();
        wait_done(200);
        pat_en = 1'b0;
        step();
        out_ready = 1'b1;
        chk("t3_left", exp_q.size(), 0);
        chk("t3_pcount", particle_count, 10);
        chk("t3_cerr", count_err, 1'b0);

        // count 250 clamps to 219
        load_cell(250);
        pulse_start();
        wait_done(400);
        chk("t4_cerr", count_err, 1'b1);
        chk("t4_pcount", particle_count, 219);
        chk("t4_left", exp_q.size(), 0);
        step();

        // reset while pid 5 of 10 is pending
        load_cell(10);
        pulse_start();
        chk("t5_cerr_cleared", count_err, 1'b0);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (out_valid && out_pid == 5) found = 1;
            else step();
        end
        chk("t5_pid5_seen", found, 1);
        out_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        check_all_zero("t5_after_rst");
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t5_no_stale", out_valid, 1'b0);
        end
        load_cell(10);
        pulse_start();
        wait_done(100);
        chk("t5_left", exp_q.size(), 0);
        step();

        // start re-pulsed mid-stream and during the finish cycle
        load_cell(10);
        pulse_start();
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
            if (done) ndone++;
            start = (k == 4) || done;
            step();
        end
        start = 1'b0;
        chk("t6_one_done", ndone, 1);
        chk("t6_idle", busy, 1'b0);
        chk("t6_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cell_pos_streamer.md
Name: cell_pos_streamer

Overview:
- Read-side controller for one per-cell position memory; sits directly downstream of the cell RAM.
- On `start`, reads the particle count at address 0, then reads addresses 1..count.
- Delivers each `{posz, posy, posx}` word on a valid/ready stream to the force-evaluation and motion-update consumers.
- Absorbs the RAM's fixed 2-cycle read latency with a credit-controlled skid FIFO, so downstream backpressure never loses data.

Parameters:
- DATA_WIDTH, 96, position word width `{posz, posy, posx}`, 32 bits each.
- ADDR_WIDTH, 8, RAM address width.
- PARTICLE_NUM, 220, RAM depth in words. Maximum legal count is PARTICLE_NUM-1.
- FIFO_DEPTH, 4, skid FIFO entries. Must be at least 3.

Ports:
- clk  in  1  single clock, shared with the cell RAM.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to stream the cell. Ignored while busy=1.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_rden  out  1  RAM read enable.
- mem_wren  out  1  RAM write enable. Tied 0.
- mem_q  in  DATA_WIDTH  RAM read data, valid 2 cycles after the address/rden cycle.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer accept.
- out_pos  out  DATA_WIDTH  particle position word.
- out_pid  out  ADDR_WIDTH  particle index, equal to its RAM address (1..count).
- out_last  out  1  high with the final particle of the cell.
- particle_count  out  ADDR_WIDTH  count latched from address 0, after clamping.
- count_err  out  1  sticky until next start: raw count exceeded PARTICLE_NUM-1.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE; FIFO flushed; in-flight tracking cleared.
  - All outputs 0: mem_addr, mem_rden, out_valid, out_pos, out_pid, out_last, particle_count, count_err, busy, done.
  - Reset mid-operation aborts immediately. No done pulse. RAM data returning after reset is discarded.
- Handshake:
  - A transfer occurs on a cycle with out_valid and out_ready both high.
  - While out_valid=1 and no transfer occurs, out_pos, out_pid and out_last hold stable.
  - out_valid never deasserts without a transfer.
- Read pipeline:
  - A 2-bit delay-line shift register tracks issued reads.
  - The RAM word for a read issued in cycle t is pushed into the FIFO at the end of cycle t+2.
  - The FIFO head drives the outputs.
  - FIFO push and pop may occur in the same cycle.
- Credit rule: a particle read is issued in a cycle only if (reads in flight + FIFO occupancy) <= FIFO_DEPTH-1. This guarantees the FIFO never overflows. With out_ready held at 1, one particle is delivered per cycle.
- State machine:
  - IDLE: on start, set busy=1, clear count_err, go to RD_CNT.
  - RD_CNT (1 cycle): mem_rden=1, mem_addr=0. Go to WAIT_CNT.
  - WAIT_CNT (2 cycles): in the second cycle, capture `mem_q[ADDR_WIDTH-1:0]`.
    - If the raw value exceeds PARTICLE_NUM-1: clamp to PARTICLE_NUM-1 and set count_err=1.
    - If count is 0: go to FINISH.
    - Otherwise: next_addr=1, go to ISSUE.
  - ISSUE: when the credit rule allows, mem_rden=1 and mem_addr=next_addr, then increment next_addr. After issuing address count, go to DRAIN.
  - DRAIN: wait until the transfer of the entry with out_last=1. Go to FINISH.
  - FINISH (1 cycle): done=1, busy=0. Go to IDLE.
- Timing from a start sampled at edge E0:
  - Count read is issued in the cycle after E0.
  - First particle read is issued 3 cycles later.
  - First out_valid is asserted in the 7th cycle after E0.
- Ordering and flags:
  - out_last=1 exactly on the entry with out_pid=count.
  - Particles are emitted in strictly increasing pid order.
- start arriving while busy=1, including in the FINISH cycle, is ignored.
- When mem_rden=0, mem_addr holds its last value.

Test Plan:
- Address 0 holds 3, ready held 1, start pulsed → out_pid 1, 2, 3 in 3 consecutive cycles beginning 7 cycles after start; out_last only on pid 3; done pulses the next cycle; particle_count=3.
- Address 0 holds 0 → no out_valid ever; done pulses 4 cycles after start; busy high for exactly 3 cycles before done.
- Count 10, out_ready toggling 1,0,0,1,… → all 10 words delivered in order, no duplicates or losses; outputs stable during stalls; FIFO occupancy never exceeds 4; no read issued while credits are exhausted.
- Count 250 with PARTICLE_NUM=220 → count_err=1; particle_count=219; last pid=219; no address ≥220 ever issued.
- rst asserted while pid 5 of 10 is pending → next cycle all outputs 0 and state IDLE; stale RAM data not emitted; a new start then streams from pid 1 correctly.
- start pulsed again mid-stream → ignored; exactly one done pulse; pid sequence unaffected.
